// File: rtl/cache_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : cache_mem_arbiter
// Description : Shares a single physical-memory line port between the
//               I-cache and D-cache miss paths. One requester is granted at a
//               time. Its address, write line and command are latched into
//               registered pmem outputs. The pmem completion is routed back to
//               the granted cache only.
// Ports       : clk, rst_n                 clock, async active-low reset
//               i_read/i_addr              I-cache line read request
//               i_rdata/i_resp             I-cache read line / completion pulse
//               d_read/d_write/d_addr      D-cache refill / writeback request
//               d_wdata                    D-cache writeback line
//               d_rdata/d_resp             D-cache read line / completion pulse
//               pmem_read/pmem_write       registered memory command
//               pmem_addr/pmem_wdata       registered address / write line
//               pmem_rdata/pmem_resp       memory read line / completion pulse
// Revision    : 1.0 - initial release
// ============================================================================
module cache_mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_addr,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp
);

    localparam logic [1:0] c_ST_IDLE    = 2'd0;
    localparam logic [1:0] c_ST_SERVE_I = 2'd1;
    localparam logic [1:0] c_ST_SERVE_D = 2'd2;

    logic [1:0]        r_state;
    logic              r_last_d;      // 1: last contended grant went to D
    logic              r_pmem_read;
    logic              r_pmem_write;
    logic [ADDR_W-1:0] r_pmem_addr;
    logic [LINE_W-1:0] r_pmem_wdata;

    logic w_ireq;
    logic w_dreq;
    logic w_both;
    logic w_grant_d;
    logic w_grant_i;

    always_comb begin
        w_ireq    = i_read;
        w_dreq    = d_read | d_write;
        w_both    = w_ireq & w_dreq;
        // On contention the side opposite to the last contended winner goes.
        w_grant_d = w_dreq & (~w_ireq | ~r_last_d);
        w_grant_i = w_ireq & ~w_grant_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= c_ST_IDLE;
            r_last_d     <= 1'b0;
            r_pmem_read  <= 1'b0;
            r_pmem_write <= 1'b0;
            r_pmem_addr  <= '0;
            r_pmem_wdata <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (w_grant_d) begin
                        r_state      <= c_ST_SERVE_D;
                        r_pmem_addr  <= d_addr;
                        // Writeback wins over refill when both are raised.
                        r_pmem_write <= d_write;
                        r_pmem_read  <= ~d_write;
                        if (d_write) begin
                            r_pmem_wdata <= d_wdata;
                        end
                        if (w_both) begin
                            r_last_d <= 1'b1;
                        end
                    end else if (w_grant_i) begin
                        r_state      <= c_ST_SERVE_I;
                        r_pmem_addr  <= i_addr;
                        r_pmem_read  <= 1'b1;
                        r_pmem_write <= 1'b0;
                        if (w_both) begin
                            r_last_d <= 1'b0;
                        end
                    end
                end
                c_ST_SERVE_I, c_ST_SERVE_D: begin
                    // Command and address stay frozen until memory completes.
                    if (pmem_resp) begin
                        r_state      <= c_ST_IDLE;
                        r_pmem_read  <= 1'b0;
                        r_pmem_write <= 1'b0;
                    end
                end
                default: begin
                    r_state      <= c_ST_IDLE;
                    r_pmem_read  <= 1'b0;
                    r_pmem_write <= 1'b0;
                end
            endcase
        end
    end

    // Completion is passed straight through to the granted side only; a
    // stray pmem_resp while idle produces nothing.
    assign i_resp     = (r_state == c_ST_SERVE_I) & pmem_resp;
    assign d_resp     = (r_state == c_ST_SERVE_D) & pmem_resp;
    assign i_rdata    = pmem_rdata;
    assign d_rdata    = pmem_rdata;

    assign pmem_read  = r_pmem_read;
    assign pmem_write = r_pmem_write;
    assign pmem_addr  = r_pmem_addr;
    assign pmem_wdata = r_pmem_wdata;

endmodule
`default_nettype wire
